// File: rtl/cpu_defs.sv
// cpu_defs: CP0 register addresses, exception codes and register layouts shared by the CP0 block
package cpu_defs;

    localparam logic [7:0] CR_BADVADDR = 8'h40;
    localparam logic [7:0] CR_COUNT    = 8'h48;
    localparam logic [7:0] CR_COMPARE  = 8'h58;
    localparam logic [7:0] CR_STATUS   = 8'h60;
    localparam logic [7:0] CR_CAUSE    = 8'h68;
    localparam logic [7:0] CR_EPC      = 8'h70;

    localparam logic [4:0] EXCCODE_INT  = 5'h00;
    localparam logic [4:0] EXCCODE_MOD  = 5'h01;
    localparam logic [4:0] EXCCODE_TLBL = 5'h02;
    localparam logic [4:0] EXCCODE_TLBS = 5'h03;
    localparam logic [4:0] EXCCODE_ADEL = 5'h04;
    localparam logic [4:0] EXCCODE_ADES = 5'h05;
    localparam logic [4:0] EXCCODE_SYS  = 5'h08;
    localparam logic [4:0] EXCCODE_BP   = 5'h09;
    localparam logic [4:0] EXCCODE_RI   = 5'h0a;
    localparam logic [4:0] EXCCODE_CPU  = 5'h0b;
    localparam logic [4:0] EXCCODE_OV   = 5'h0c;

    typedef struct packed {
        logic [8:0] zero_hi;
        logic       bev;
        logic [5:0] zero_mid;
        logic [7:0] im;
        logic [5:0] zero_lo;
        logic       exl;
        logic       ie;
    } cp0_status_t;

    typedef struct packed {
        logic        bd;
        logic        ti;
        logic [13:0] zero_hi;
        logic [7:0]  ip;
        logic        zero_mid;
        logic [4:0]  exc_code;
        logic [1:0]  zero_lo;
    } cp0_cause_t;

    typedef struct packed {
        logic        ex_valid;
        logic        ex_bd;
        logic [4:0]  ex_code;
        logic [31:0] ex_badvaddr;
        logic [31:0] ex_pc;
        logic        eret;
    } ws_to_c0_bus_t;

    // Only address-related faults capture the faulting virtual address.
    function automatic logic badvaddr_code(input logic [4:0] code);
        return code inside {EXCCODE_MOD, EXCCODE_TLBL, EXCCODE_TLBS, EXCCODE_ADEL, EXCCODE_ADES};
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: CP0 Count/Compare timer with clock prescaler and sticky timer-interrupt flag
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        we_count,
    input  logic        we_compare,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam int PW = COUNT_DIV > 1 ? $clog2(COUNT_DIV) : 1;

    logic [PW-1:0] pre;
    logic          tick;
    logic [31:0]   count_next;

    assign tick       = pre == PW'(COUNT_DIV - 1);
    assign count_next = we_count ? wdata : count + {31'd0, tick};

    // Prescaler, Count and Compare; TI latches on a match with the post-increment Count, a Compare write clears it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pre     <= '0;
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            pre     <= (we_count || tick) ? '0 : pre + 1'b1;
            count   <= count_next;
            if (we_compare)
                compare <= wdata;
            ti      <= we_compare ? 1'b0 : (ti | (count_next == compare));
        end
    end

endmodule

// File: rtl/cp0_exc_unit.sv
// cp0_exc_unit: CP0 registers + exception/interrupt control; timer built only with `CP0_TIMER_EN
module cp0_exc_unit
    import cpu_defs::*;
#(
    parameter int          HW_INT_NUM   = 6,
    parameter int          COUNT_DIV    = 2,
    parameter logic [31:0] EXC_VEC_BEV  = 32'hBFC00380,
    parameter logic [31:0] EXC_VEC_NORM = 32'h80000180
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  c0_we,
    input  logic [7:0]            c0_addr,
    input  logic [31:0]           c0_wdata,
    output logic [31:0]           c0_rdata,
    input  logic [HW_INT_NUM-1:0] ext_int,
    input  logic                  ex_valid,
    input  logic                  ex_bd,
    input  logic [4:0]            ex_code,
    input  logic [31:0]           ex_badvaddr,
    input  logic [31:0]           ex_pc,
    input  logic                  eret,
    output logic                  flush,
    output logic [31:0]           flush_target,
    output logic                  int_pending,
    output logic                  status_exl
);

    if (HW_INT_NUM < 1 || HW_INT_NUM > 6 || COUNT_DIV < 1) begin : g_param_check
        $error("cp0_exc_unit: HW_INT_NUM must be 1..6 and COUNT_DIV >= 1");
    end

    ws_to_c0_bus_t ws;
    cp0_status_t   status;
    cp0_cause_t    cause;
    logic [7:0]    st_im;
    logic          st_exl;
    logic          st_ie;
    logic [1:0]    ip_sw;
    logic [5:0]    hw_ip;
    logic          bd;
    logic [4:0]    exc_code;
    logic [31:0]   epc;
    logic [31:0]   badvaddr;
    logic [31:0]   count;
    logic [31:0]   compare;
    logic          ti;

    assign ws = '{ex_valid, ex_bd, ex_code, ex_badvaddr, ex_pc, eret};

`ifdef CP0_TIMER_EN
    logic mtc0;
    assign mtc0 = c0_we & ~ex_valid & ~eret;
    cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .we_count   (mtc0 && c0_addr == CR_COUNT),
        .we_compare (mtc0 && c0_addr == CR_COMPARE),
        .wdata      (c0_wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );
`else
    assign count   = '0;
    assign compare = '0;
    assign ti      = 1'b0;
`endif

    // Register state: exception commit beats ERET beats MTC0; IP[7:2] follows the interrupt lines one cycle late.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st_im    <= '0;
            st_exl   <= 1'b0;
            st_ie    <= 1'b0;
            ip_sw    <= '0;
            hw_ip    <= '0;
            bd       <= 1'b0;
            exc_code <= '0;
            epc      <= '0;
            badvaddr <= '0;
        end else begin
            hw_ip <= 6'(ext_int);
            if (ws.ex_valid) begin
                if (!st_exl) begin
                    epc <= ws.ex_bd ? ws.ex_pc - 32'd4 : ws.ex_pc;
                    bd  <= ws.ex_bd;
                end
                st_exl   <= 1'b1;
                exc_code <= ws.ex_code;
                if (badvaddr_code(ws.ex_code))
                    badvaddr <= ws.ex_badvaddr;
            end else if (ws.eret) begin
                st_exl <= 1'b0;
            end else if (c0_we) begin
                if (c0_addr == CR_STATUS) begin
                    st_im  <= c0_wdata[15:8];
                    st_exl <= c0_wdata[1];
                    st_ie  <= c0_wdata[0];
                end
                if (c0_addr == CR_CAUSE)
                    ip_sw <= c0_wdata[9:8];
                if (c0_addr == CR_EPC)
                    epc <= c0_wdata;
            end
        end
    end

    assign status = '{zero_hi: '0, bev: 1'b1, zero_mid: '0, im: st_im, zero_lo: '0, exl: st_exl, ie: st_ie};
    assign cause  = '{bd: bd, ti: ti, zero_hi: '0, ip: {hw_ip[5] | ti, hw_ip[4:0], ip_sw},
                      zero_mid: 1'b0, exc_code: exc_code, zero_lo: '0};

    // MFC0 read mux over current register state; unmapped addresses read zero.
    always_comb begin
        case (c0_addr)
            CR_BADVADDR: c0_rdata = badvaddr;
            CR_COUNT:    c0_rdata = count;
            CR_COMPARE:  c0_rdata = compare;
            CR_STATUS:   c0_rdata = status;
            CR_CAUSE:    c0_rdata = cause;
            CR_EPC:      c0_rdata = epc;
            default:     c0_rdata = '0;
        endcase
    end

    assign flush        = ex_valid | eret;
    assign flush_target = ex_valid ? (status.bev ? EXC_VEC_BEV : EXC_VEC_NORM) : epc;
    assign int_pending  = st_ie & ~st_exl & |(cause.ip & st_im);
    assign status_exl   = st_exl;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// tb_cp0_exc_unit: directed + randomized checks of cp0_exc_unit against a behavioural CP0 model (honours CP0_TIMER_EN)
module tb_cp0_exc_unit;

    localparam int HW = 6;
    localparam int DIV = 2;
`ifdef CP0_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn;
    logic          c0_we;
    logic [7:0]    c0_addr;
    logic [31:0]   c0_wdata;
    logic [31:0]   c0_rdata;
    logic [HW-1:0] ext_int;
    logic          ex_valid;
    logic          ex_bd;
    logic [4:0]    ex_code;
    logic [31:0]   ex_badvaddr;
    logic [31:0]   ex_pc;
    logic          eret;
    logic          flush;
    logic [31:0]   flush_target;
    logic          int_pending;
    logic          status_exl;

    int checks = 0;
    int failures = 0;

    cp0_exc_unit #(.HW_INT_NUM(HW), .COUNT_DIV(DIV)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .c0_we        (c0_we),
        .c0_addr      (c0_addr),
        .c0_wdata     (c0_wdata),
        .c0_rdata     (c0_rdata),
        .ext_int      (ext_int),
        .ex_valid     (ex_valid),
        .ex_bd        (ex_bd),
        .ex_code      (ex_code),
        .ex_badvaddr  (ex_badvaddr),
        .ex_pc        (ex_pc),
        .eret         (eret),
        .flush        (flush),
        .flush_target (flush_target),
        .int_pending  (int_pending),
        .status_exl   (status_exl)
    );

    always #5 clk = ~clk;

    // behavioural model: architectural fields, timer as load value plus elapsed cycles
    logic [7:0]  m_im;
    logic        m_exl, m_ie, m_bd, m_ti;
    logic [1:0]  m_ipsw;
    logic [4:0]  m_code;
    logic [31:0] m_epc, m_bva, m_base, m_cmp;
    logic [5:0]  m_hw;
    int unsigned m_cyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_ipsw = 0; m_code = 0;
        m_epc = 0; m_bva = 0; m_base = 0; m_cmp = 0; m_hw = 0; m_cyc = 0;
    endtask

    function automatic logic [31:0] m_count();
        return TIMER ? m_base + 32'(m_cyc / DIV) : 32'd0;
    endfunction

    function automatic logic [7:0] m_ip();
        return {m_hw[5] | m_ti, m_hw[4:0], m_ipsw};
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a);
        case (a)
            8'h40: return m_bva;
            8'h48: return m_count();
            8'h58: return m_cmp;
            8'h60: return 32'h0040_0000 | {16'd0, m_im, 8'd0} | {30'd0, m_exl, m_ie};
            8'h68: return {m_bd, m_ti, 14'd0, m_ip(), 1'b0, m_code, 2'b00};
            8'h70: return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_step();
        bit cload, cmpw;
        cload = 0;
        cmpw = 0;
        if (ex_valid) begin
            if (!m_exl) begin
                m_epc = ex_bd ? ex_pc - 32'd4 : ex_pc;
                m_bd = ex_bd;
            end
            m_exl = 1;
            m_code = ex_code;
            if (ex_code >= 5'd1 && ex_code <= 5'd5) m_bva = ex_badvaddr;
        end else if (eret) begin
            m_exl = 0;
        end else if (c0_we) begin
            case (c0_addr)
                8'h60: begin m_im = c0_wdata[15:8]; m_exl = c0_wdata[1]; m_ie = c0_wdata[0]; end
                8'h68: m_ipsw = c0_wdata[9:8];
                8'h70: m_epc = c0_wdata;
                8'h48: cload = TIMER;
                8'h58: cmpw = TIMER;
                default: ;
            endcase
        end
        if (cload) begin m_base = c0_wdata; m_cyc = 0; end
        else m_cyc++;
        if (cmpw) begin m_cmp = c0_wdata; m_ti = 0; end
        else if (TIMER && m_count() == m_cmp) m_ti = 1;
        m_hw = 6'(ext_int);
    endtask

    task automatic idle();
        c0_we = 0; c0_addr = 8'h60; c0_wdata = 0; ex_valid = 0; ex_bd = 0;
        ex_code = 0; ex_badvaddr = 0; ex_pc = 0; eret = 0;
    endtask

    task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
        idle();
        c0_we = 1; c0_addr = a; c0_wdata = d;
    endtask

    // one clock: compare all outputs mid-cycle, then advance model at the edge
    task automatic cyc();
        @(negedge clk);
        chk("rdata", c0_rdata, m_read(c0_addr));
        chk("flush", flush, ex_valid | eret);
        if (ex_valid | eret) chk("target", flush_target, ex_valid ? 32'hBFC00380 : m_epc);
        chk("int_pending", int_pending, m_ie & ~m_exl & |(m_ip() & m_im));
        chk("status_exl", status_exl, m_exl);
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic do_reset();
        resetn = 0;
        idle();
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        c0_addr = 8'h60;
        #1 chk("rst_status", c0_rdata, 32'h0040_0000);
        c0_addr = 8'h68;
        #1 chk("rst_cause", c0_rdata, 32'h0);
        chk("rst_flush", flush, 0);
        chk("rst_intp", int_pending, 0);
        chk("rst_exl", status_exl, 0);
        resetn = 1;
    endtask

    logic [7:0] addrs [8] = '{8'h40, 8'h48, 8'h58, 8'h60, 8'h68, 8'h70, 8'h00, 8'h61};

    initial begin
        ext_int = 0;
        do_reset();
        mtc0(8'h58, 32'hFFFF_0000);
        cyc();
        // exception in delay slot, then nested exception with EXL already set
        idle();
        ex_valid = 1; ex_code = 5'd4; ex_pc = 32'hBFC0_0100; ex_bd = 1; ex_badvaddr = 32'h3;
        #1 chk("ex_flush", flush, 1);
        chk("ex_target", flush_target, 32'hBFC0_0380);
        cyc();
        idle(); c0_addr = 8'h70;
        #1 chk("ex_epc", c0_rdata, 32'hBFC0_00FC);
        c0_addr = 8'h68;
        #1 chk("ex_cause", c0_rdata, 32'h8000_0010);
        c0_addr = 8'h40;
        #1 chk("ex_bva", c0_rdata, 32'h3);
        chk("ex_exl", status_exl, 1);
        ex_valid = 1; ex_code = 5'd5; ex_pc = 32'h1000; ex_bd = 0; ex_badvaddr = 32'h44;
        cyc();
        idle(); c0_addr = 8'h70;
        #1 chk("ex2_epc", c0_rdata, 32'hBFC0_00FC);
        c0_addr = 8'h68;
        #1 chk("ex2_cause", c0_rdata, 32'h8000_0014);
        // ERET racing an MTC0 EPC
        mtc0(8'h70, 32'h8000_1000);
        cyc();
        mtc0(8'h70, 32'h0); eret = 1;
        #1 chk("eret_target", flush_target, 32'h8000_1000);
        cyc();
        idle(); c0_addr = 8'h70;
        #1 chk("eret_epc", c0_rdata, 32'h8000_1000);
        chk("eret_exl", status_exl, 0);
        // interrupt enable / mask / EXL gating
        mtc0(8'h60, 32'h0000_0401);
        cyc();
        idle(); ext_int = 1;
        cyc();
        c0_addr = 8'h68;
        #1 chk("ip2", c0_rdata[10], 1);
        chk("intp_on", int_pending, 1);
        mtc0(8'h60, 32'h0000_0403);
        cyc();
        chk("intp_exl", int_pending, 0);
        ext_int = 0;
        mtc0(8'h60, 32'h0);
        cyc();
`ifdef CP0_TIMER_EN
        mtc0(8'h48, 32'hFFFF_FFFE);
        cyc();
        mtc0(8'h58, 32'h0);
        cyc();
        idle();
        cyc();
        cyc();
        c0_addr = 8'h48;
        #1 chk("tmr_count", c0_rdata, 32'h0);
        c0_addr = 8'h68;
        #1 chk("tmr_ti", c0_rdata[30], 1);
        chk("tmr_ip7", c0_rdata[15], 1);
        mtc0(8'h58, 32'h5);
        cyc();
        idle(); c0_addr = 8'h68;
        #1 chk("tmr_ti_clr", c0_rdata[30], 0);
`else
        mtc0(8'h48, 32'h55);
        cyc();
        idle(); c0_addr = 8'h48;
        #1 chk("notmr_count", c0_rdata, 32'h0);
        c0_addr = 8'h68;
        #1 chk("notmr_ti", c0_rdata[30], 0);
`endif
        // randomized traffic with one mid-run reset
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            idle();
            ex_valid = $urandom_range(0, 15) == 0;
            eret = $urandom_range(0, 15) == 0;
            c0_we = $urandom_range(0, 2) == 0;
            c0_addr = addrs[$urandom_range(0, 7)];
            c0_wdata = $urandom;
            if (c0_addr == 8'h58 && $urandom_range(0, 1) == 1) c0_wdata = m_count() + $urandom_range(0, 6);
            if (c0_addr == 8'h60 && $urandom_range(0, 1) == 1) c0_wdata = c0_wdata & 32'hFFFF_FFFD;
            ex_bd = 1'($urandom);
            ex_code = 5'($urandom_range(0, 13));
            ex_pc = $urandom;
            ex_badvaddr = $urandom;
            if ($urandom_range(0, 7) == 0) ext_int = HW'($urandom);
            cyc();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
